// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and state encoding for the serial-in/parallel-out deserializer.
package sipo_pkg;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SHIFTING = 1'b1
  } state_e;

endpackage

// File: rtl/sipo_deserializer_out_buffer.sv
// Single-entry output holding register with valid/ready handshake and sticky overrun flag.
module sipo_out_buffer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             word_valid_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             po_ready,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;
  logic             slot_free;

  // The slot is free when empty, or when the held word is consumed on this same edge.
  assign slot_free = !po_valid_q || po_ready;

  always_comb begin
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;

    if (word_valid_i) begin
      if (slot_free) begin
        po_d       = word_i;
        po_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (po_valid_q && po_ready) begin
      po_valid_d = 1'b0;
    end

    if (clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: bit counter, shift register and IDLE/SHIFTING FSM,
// feeding a single-entry output buffer.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter string       SHIFT_DIRECTION = DIR_LEFT,
  parameter int unsigned WIDTH           = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     si,
  input  logic                     si_valid,
  output logic [WIDTH-1:0]         po,
  output logic                     po_valid,
  input  logic                     po_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam bit          IS_LEFT = (SHIFT_DIRECTION == DIR_LEFT);
  localparam bit          IS_RIGHT = (SHIFT_DIRECTION == DIR_RIGHT);

  // Reject unsupported configurations at elaboration.
  if (!(IS_LEFT || IS_RIGHT)) begin : g_bad_dir
    $error("sipo_deserializer: SHIFT_DIRECTION must be \"LEFT\" or \"RIGHT\"");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("sipo_deserializer: WIDTH must be at least 2");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   shifted;
  logic               word_done;

  // LEFT: MSB-first, new bit at bit 0. RIGHT: LSB-first, new bit at the top bit.
  assign shifted = IS_LEFT ? {sr_q[WIDTH-2:0], si} : {si, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (si_valid) begin
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        word_done = 1'b1;
        state_d   = ST_IDLE;
        cnt_d     = '0;
        sr_d      = '0;
      end else begin
        state_d = ST_SHIFTING;
        cnt_d   = cnt_q + CNT_W'(1);
        sr_d    = shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign busy    = (state_q == ST_SHIFTING);
  assign bit_cnt = cnt_q;

  // The completed word is the shift register with the final bit already folded in.
  sipo_out_buffer #(
    .WIDTH (WIDTH)
  ) u_out_buffer (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .word_valid_i (word_done),
    .word_i       (shifted),
    .po_ready     (po_ready),
    .po           (po),
    .po_valid     (po_valid),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: a LEFT and a RIGHT instance share stimulus; expected values are hand-computed.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       si;
  logic       si_valid;
  logic       po_ready;

  logic [7:0] po_l, po_r;
  logic       po_valid_l, po_valid_r;
  logic       busy_l, busy_r;
  logic [2:0] bit_cnt_l, bit_cnt_r;
  logic       overrun_l, overrun_r;

  int n_checks;
  int n_errors;

  sipo_deserializer #(.SHIFT_DIRECTION("LEFT"), .WIDTH(8)) dut_l (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .si       (si),
    .si_valid (si_valid),
    .po       (po_l),
    .po_valid (po_valid_l),
    .po_ready (po_ready),
    .busy     (busy_l),
    .bit_cnt  (bit_cnt_l),
    .overrun  (overrun_l)
  );

  sipo_deserializer #(.SHIFT_DIRECTION("RIGHT"), .WIDTH(8)) dut_r (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .si       (si),
    .si_valid (si_valid),
    .po       (po_r),
    .po_valid (po_valid_r),
    .po_ready (po_ready),
    .busy     (busy_r),
    .bit_cnt  (bit_cnt_r),
    .overrun  (overrun_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    si       = b;
    si_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    si_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // MSB-first sequence of w on consecutive edges; si_valid left high.
  task automatic send_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) send_bit(w[k]);
  endtask

  logic [7:0] seq;
  logic [7:0] words [3];
  int         pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    po_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_po",       32'(po_l),       32'h00);
    check("rst_po_valid", 32'(po_valid_l), 32'h0);
    check("rst_bit_cnt",  32'(bit_cnt_l),  32'h0);
    check("rst_busy",     32'(busy_l),     32'h0);
    check("rst_overrun",  32'(overrun_l),  32'h0);
    rst = 1'b0;

    // Bits 1,0,1,1,0,0,1,0 back to back: LEFT B2, RIGHT 4D
    po_ready = 1'b1;
    seq      = 8'b1011_0010;
    for (int k = 7; k >= 1; k--) send_bit(seq[k]);
    check("basic_valid_early", 32'(po_valid_l), 32'h0);
    check("basic_busy",        32'(busy_l),     32'h1);
    send_bit(seq[0]);
    check("basic_l_valid", 32'(po_valid_l), 32'h1);
    check("basic_l_po",    32'(po_l),       32'hB2);
    check("basic_r_valid", 32'(po_valid_r), 32'h1);
    check("basic_r_po",    32'(po_r),       32'h4D);
    check("basic_cnt_wrap", 32'(bit_cnt_l), 32'h0);
    idle(1);
    check("basic_pulse_end", 32'(po_valid_l), 32'h0);
    check("basic_po_held",   32'(po_l),       32'hB2);

    // Same bits with 3-cycle gaps on the RIGHT instance
    for (int k = 7; k >= 0; k--) begin
      send_bit(seq[k]);
      if (k != 0) begin
        idle(3);
        check("gap_busy",    32'(busy_r),    32'h1);
        check("gap_bit_cnt", 32'(bit_cnt_r), 32'(8 - k));
      end
    end
    check("gap_r_valid", 32'(po_valid_r), 32'h1);
    check("gap_r_po",    32'(po_r),       32'h4D);
    check("gap_busy_end", 32'(busy_r),    32'h0);
    idle(1);

    // Consumer stalled: second word dropped, overrun sticky until clear
    po_ready = 1'b0;
    send_word(8'hB2);
    check("ovr_first_po", 32'(po_l), 32'hB2);
    send_word(8'hFF);
    idle(1);
    check("ovr_po",       32'(po_l),       32'hB2);
    check("ovr_po_valid", 32'(po_valid_l), 32'h1);
    check("ovr_flag",     32'(overrun_l),  32'h1);
    idle(2);
    check("ovr_sticky",   32'(overrun_l),  32'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_overrun",  32'(overrun_l),  32'h0);
    check("clr_po",       32'(po_l),       32'hB2);
    check("clr_po_valid", 32'(po_valid_l), 32'h1);
    po_ready = 1'b1;
    idle(1);
    check("drain_valid", 32'(po_valid_l), 32'h0);

    // Back-to-back words: pulses at edges 7, 15, 23
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h00;
    pulses   = 0;
    for (int i = 0; i < 24; i++) begin
      seq = words[i / 8];
      send_bit(seq[7 - (i % 8)]);
      if (po_valid_l) begin
        if (pulses < 3) begin
          check("b2b_po",   32'(po_l), 32'(words[pulses]));
          check("b2b_edge", 32'(i),    32'(8 * pulses + 7));
        end
        pulses++;
      end
    end
    idle(1);
    check("b2b_pulses",  32'(pulses),     32'd3);
    check("b2b_overrun", 32'(overrun_l),  32'h0);

    // Reset mid-word discards partial bits
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    si_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_bit_cnt", 32'(bit_cnt_l), 32'h0);
    check("midrst_busy",    32'(busy_l),    32'h0);
    seq = 8'h81;
    for (int k = 7; k >= 1; k--) send_bit(seq[k]);
    check("midrst_no_early", 32'(po_valid_l), 32'h0);
    send_bit(seq[0]);
    check("midrst_po",    32'(po_l),       32'h81);
    check("midrst_valid", 32'(po_valid_l), 32'h1);
    idle(1);

    // Clear with si_valid at bit_cnt=5: bit dropped, pending word kept
    po_ready = 1'b0;
    send_word(8'h3C);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    check("clr5_bit_cnt_pre", 32'(bit_cnt_l), 32'd5);
    clear = 1'b1;
    send_bit(1'b1);
    clear    = 1'b0;
    si_valid = 1'b0;
    check("clr5_bit_cnt",  32'(bit_cnt_l),  32'h0);
    check("clr5_busy",     32'(busy_l),     32'h0);
    check("clr5_po",       32'(po_l),       32'h3C);
    check("clr5_po_valid", 32'(po_valid_l), 32'h1);
    po_ready = 1'b1;
    send_word(8'h5A);
    check("clr5_next_po",    32'(po_l),       32'h5A);
    check("clr5_next_valid", 32'(po_valid_l), 32'h1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
